serial_add_ctrl: RTL and testbench

Bit-serial adder control and datapath stage that sits directly upstream of the 9-bit serial result shifter. It latches two WIDTH-bit operands on a start request and streams their sum through one full adder with a carry flip-flop, LSB first. It then emits the final carry as bit WIDTH. `sum_bit` and `shift_en` connect straight to the shifter's serial input and enable, so after WIDTH+1 enabled cycles the shifter holds {carry, sum}.

---
 rtl/serial_add_ctrl_if.sv | 53 +++++
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle between a client and the bit-serial adder stage.
//
// Signals:
//   start      operation request, sampled only while the adder is idle
//   a_in       operand A, captured on the edge that accepts start
//   b_in       operand B, captured on the edge that accepts start
//   sub        subtract select (only when SERIAL_ADD_SUB_EN is defined)
//   sum_bit    serial result bit feeding the downstream shifter
//   shift_en   downstream shifter enable, high WIDTH+1 cycles per operation
//   busy       high while bits are being produced (ADD and CARRY)
//   done       one-cycle pulse; the shifter result is valid in this cycle
//   carry_out  registered final carry / not-borrow of the last operation
//
// Modports: master = client side, slave = adder side.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub signal.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             sum_bit;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic             carry_out;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a_in, b_in, sub,
        input  sum_bit, shift_en, busy, done, carry_out
    );
    modport slave (
        input  start, a_in, b_in, sub,
        output sum_bit, shift_en, busy, done, carry_out
    );
`else
    modport master (
        output start, a_in, b_in,
        input  sum_bit, shift_en, busy, done, carry_out
    );
    modport slave (
        input  start, a_in, b_in,
        output sum_bit, shift_en, busy, done, carry_out
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder stage. On an accepted start it latches two WIDTH-bit
// operands, then streams their sum LSB first through one full adder and a
// carry flip-flop, followed by the final carry as bit WIDTH. sum_bit and
// shift_en drive a WIDTH+1 bit downstream shifter directly, so at done the
// shifter holds {carry, sum}.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; abandons any operation in flight
//   bus   serial_add_ctrl_if.slave (start/a_in/b_in[/sub] in;
//         sum_bit/shift_en/busy/done/carry_out out)
//
// Optional feature macro: SERIAL_ADD_SUB_EN enables subtraction
// (a - b computed as a + ~b + 1; carry_out is then not-borrow).
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        CARRY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             carry_out_q;

    // Operand B and carry-in as loaded at accept time.
    logic [WIDTH-1:0] b_load;
    logic             cin;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and inject the +1 through the carry.
    assign b_load = bus.sub ? ~bus.b_in : bus.b_in;
    assign cin    = bus.sub;
`else
    assign b_load = bus.b_in;
    assign cin    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a signal unassigned and no latch forms.
    always_comb begin
        state_next   = state;
        bus.sum_bit  = 1'b0;
        bus.shift_en = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                bus.shift_en = 1'b1;
                bus.busy     = 1'b1;
                bus.sum_bit  = a_sr[0] ^ b_sr[0] ^ c;
                if (cnt == CNT_LAST) begin
                    state_next = CARRY;
                end
            end
            CARRY: begin
                bus.shift_en = 1'b1;
                bus.busy     = 1'b1;
                bus.sum_bit  = c;
                state_next   = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. Every register is cleared by reset so an abandoned
    // operation leaves no stale operand or carry behind.
    // NOTE: sequential state is written with non-blocking '<=' so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            c           <= 1'b0;
            cnt         <= '0;
            carry_out_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.a_in;
                        b_sr <= b_load;
                        c    <= cin;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    c    <= (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + CNT_W'(1);
                end
                CARRY: begin
                    carry_out_q <= c;
                end
                default: ;
            endcase
        end
    end

    assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl. Includes a model of the downstream
// 9-bit shifter; a scoreboard queue holds expected {shifter, carry_out} per
// accepted operation and a monitor compares at every done pulse.
// Define SERIAL_ADD_SUB_EN to also exercise subtraction.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH:0] sh;
        logic           co;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;

    // Downstream shifter model: serial input enters at the MSB.
    logic [WIDTH:0] shifter;
    always @(posedge clk) begin
        if (rst) shifter <= '0;
        else if (bus.shift_en) shifter <= {bus.sum_bit, shifter[WIDTH:1]};
    end

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_done  = 0;
    int   sh_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [WIDTH:0] sh, input logic co);
        exp_t e;
        e.sh = sh;
        e.co = co;
        exp_q.push_back(e);
        n_push++;
    endtask

    // Monitor: counts shift_en cycles and scores each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            sh_seen = 0;
        end else begin
            if (bus.shift_en) sh_seen++;
            if (bus.done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", n_done, n_push);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("shifter", 32'(shifter), 32'(e.sh));
                    check("carry_out", 32'(bus.carry_out), 32'(e.co));
                    check("shift_en_cycles", sh_seen, WIDTH + 1);
                end
                sh_seen = 0;
            end
        end
    end

    // Waits (bounded) for a done pulse; returns negedges elapsed. Called at a
    // negedge; optionally drops start after the first cycle.
    task automatic wait_done(input bit drop_start, output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            if (drop_start) bus.start = 1'b0;
            if (bus.done) begin
                got    = 1'b1;
                cycles = i;
            end
        end
        check("done_timeout", 32'(got), 32'd1);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        bus.a_in  = a;
        bus.b_in  = b;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("issue: sub requested without SERIAL_ADD_SUB_EN");
`endif
        bus.start = 1'b1;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          input logic [WIDTH:0] sh, input logic co);
        int cyc;
        @(negedge clk);
        issue(a, b, s);
        push_exp(sh, co);
        wait_done(1'b1, cyc);
        check("latency", cyc, WIDTH + 2);
    endtask

    initial begin
        int cyc;
        bit got;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_shift_en", 32'(bus.shift_en), 0);
        check("rst_sum_bit", 32'(bus.sum_bit), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_carry_out", 32'(bus.carry_out), 0);

        // Basic add, then the carry case.
        run_op(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        @(negedge clk);
        check("carry_out_held", 32'(bus.carry_out), 1);
        run_op(8'hC3, 8'h5E, 1'b0, 9'h121, 1'b1);

        // start during ADD cycle 4 is ignored.
        @(negedge clk);
        issue(8'h35, 8'h4A, 1'b0);
        push_exp(9'h07F, 1'b0);
        got = 1'b0;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 4) issue(8'h11, 8'h22, 1'b0);
            if (bus.done) begin
                got = 1'b1;
                check("latency_ignored", i, WIDTH + 2);
            end
        end
        check("done_timeout", 32'(got), 32'd1);
        repeat (15) @(negedge clk);
        check("no_extra_done", n_done, n_push);

        // Reset in ADD cycle 3 abandons the operation.
        @(negedge clk);
        issue(8'hAA, 8'h0F, 1'b0);
        push_exp(9'h0B9, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("in_add_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        n_push -= exp_q.size();
        exp_q.delete();
        @(negedge clk);
        check("abort_shift_en", 32'(bus.shift_en), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_carry_out", 32'(bus.carry_out), 0);
        check("abort_shifter", 32'(shifter), 0);
        rst = 1'b0;
        run_op(8'h02, 8'h03, 1'b0, 9'h005, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 9'h10F, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 9'h0FF, 1'b0);
        run_op(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b0);
`endif

        // start held high: three back-to-back operations.
        @(negedge clk);
        issue(8'h12, 8'h34, 1'b0);
        push_exp(9'h046, 1'b0);
        wait_done(1'b0, cyc);
        check("b2b_first_latency", cyc, WIDTH + 2);
        issue(8'h80, 8'h80, 1'b0);
        push_exp(9'h100, 1'b1);
        wait_done(1'b0, cyc);
        check("b2b_spacing", cyc, WIDTH + 3);
        issue(8'hAA, 8'h55, 1'b0);
        push_exp(9'h0FF, 1'b0);
        wait_done(1'b0, cyc);
        check("b2b_spacing", cyc, WIDTH + 3);
        bus.start = 1'b0;

        repeat (15) @(negedge clk);
        check("done_total", n_done, n_push);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
